// File: rtl/difficulty_select.sv
// Debounced four-button difficulty selector feeding the processor's difficulty_in.
// Define DIFFICULTY_LATCH_EN for a latched selection; the default build follows held buttons.
module difficulty_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        BTNL,
  input  logic        BTNC,
  input  logic        BTNR,
  input  logic        BTND,
  output logic [31:0] difficulty,
  output logic        difficulty_changed,
  output logic [3:0]  btn_level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t TERM = cnt_t'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} state_t;

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb;
  logic [3:0] deb_q;
  logic [3:0] press;
  cnt_t       cnt [4];
  state_t     state;
  state_t     next_state;

  // Bit order {BTND, BTNR, BTNC, BTNL} is shared by every 4-bit vector below.
  assign raw = {BTND, BTNR, BTNC, BTNL};

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == TERM) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else if (cnt[i] != '1) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  always_comb begin
    next_state = state;
`ifdef DIFFICULTY_LATCH_EN
    if (press[3])      next_state = D0;
    else if (press[0]) next_state = D1;
    else if (press[1]) next_state = D2;
    else if (press[2]) next_state = D3;
`else
    if (deb[3])        next_state = D0;
    else if (deb[0])   next_state = D1;
    else if (deb[1])   next_state = D2;
    else if (deb[2])   next_state = D3;
    else               next_state = D0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= D0;
      difficulty_changed <= 1'b0;
    end else begin
      state              <= next_state;
      difficulty_changed <= (next_state != state);
    end
  end

  assign difficulty = {30'd0, state};
  assign btn_level  = deb;

endmodule

// File: tb/tb_difficulty_select.sv
// Scoreboarded bench for difficulty_select with DEBOUNCE_CYCLES=4: window-based
// reference model, directed latency/glitch/priority scenarios and random button activity.
module tb_difficulty_select;

  localparam int unsigned DEB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        BTNL = 1'b0, BTNC = 1'b0, BTNR = 1'b0, BTND = 1'b0;
  logic [31:0] difficulty;
  logic        difficulty_changed;
  logic [3:0]  btn_level;

  difficulty_select #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset),
    .BTNL(BTNL), .BTNC(BTNC), .BTNR(BTNR), .BTND(BTND),
    .difficulty(difficulty), .difficulty_changed(difficulty_changed),
    .btn_level(btn_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] diff;
    logic        chg;
    logic [3:0]  lvl;
  } exp_t;

  exp_t q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses = 0;

  // Reference model: a debounced level flips once the last DEB synchronized samples
  // (raw delayed two edges) all disagree with it.
  logic [DEB:0] hist [4];
  logic [3:0]   m_deb, m_deb_prev;
  int           m_state;

  function automatic int button_value(int b);
    return (b == 3) ? 0 : b + 1;
  endfunction

  always @(posedge clock) begin
    logic [3:0] rawv, new_deb, pr;
    int nxt;
    bit all_diff;
    exp_t e;
    int order [4];
    order = '{3, 0, 1, 2};
    rawv = {BTND, BTNR, BTNC, BTNL};
    if (reset) begin
      for (int b = 0; b < 4; b++) hist[b] = '0;
      m_deb = '0; m_deb_prev = '0; m_state = 0;
      e.diff = 0; e.chg = 1'b0; e.lvl = '0;
    end else begin
      pr = m_deb & ~m_deb_prev;
`ifdef DIFFICULTY_LATCH_EN
      nxt = m_state;
      for (int k = 3; k >= 0; k--) if (pr[order[k]]) nxt = button_value(order[k]);
`else
      nxt = 0;
      for (int k = 3; k >= 0; k--) if (m_deb[order[k]]) nxt = button_value(order[k]);
`endif
      e.chg = (nxt != m_state);
      m_state = nxt;
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DEB; k++) if (hist[b][k] == m_deb[b]) all_diff = 1'b0;
        new_deb[b] = all_diff ? ~m_deb[b] : m_deb[b];
        hist[b] = {hist[b][DEB-1:0], rawv[b]};
      end
      m_deb_prev = m_deb;
      m_deb = new_deb;
      e.diff = m_state;
      e.lvl = m_deb;
    end
    q.push_back(e);
  end

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (difficulty !== e.diff || difficulty_changed !== e.chg || btn_level !== e.lvl) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t difficulty got %0d want %0d, changed got %0b want %0b, level got %b want %b",
                 $time, difficulty, e.diff, difficulty_changed, e.chg, btn_level, e.lvl);
      end
    end
    if (difficulty_changed === 1'b1) pulses++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Edges from the next posedge until difficulty shows target; -1 if never within the bound.
  task automatic measure(input int target, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (difficulty == target) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [3:0] any_level;
    wait_n(3);

    // BTNC held ~20 cycles then released
    do_reset(); pulses = 0;
    BTNC = 1'b1;
    measure(2, lat);
    check("c_latency", lat, DEB + 3);
    wait_n(13);
    BTNC = 1'b0;
    wait_n(12);
`ifdef DIFFICULTY_LATCH_EN
    check("c_pulses", pulses, 1);
    check("c_held_after_release", difficulty, 2);
`else
    check("c_pulses", pulses, 2);
    check("c_after_release", difficulty, 0);
`endif

    // Short BTNL glitches must never be accepted
    do_reset(); pulses = 0; any_level = '0;
    repeat (5) begin
      BTNL = 1'b1;
      repeat (3) begin @(negedge clock); any_level |= btn_level; end
      BTNL = 1'b0;
      repeat (3) begin @(negedge clock); any_level |= btn_level; end
    end
    wait_n(10);
    check("glitch_pulses", pulses, 0);
    check("glitch_difficulty", difficulty, 0);
    check("glitch_level", int'(any_level), 0);

    // Simultaneous BTNL+BTNR, then BTND
    do_reset(); pulses = 0;
    BTNL = 1'b1; BTNR = 1'b1;
    measure(1, lat);
    check("lr_latency", lat, DEB + 3);
    wait_n(10);
    BTND = 1'b1;
    wait_n(12);
    check("lr_then_d_difficulty", difficulty, 0);
    check("lr_then_d_pulses", pulses, 2);
    BTNL = 1'b0; BTNR = 1'b0; BTND = 1'b0;
    wait_n(12);

    // BTNR released and re-pressed while at 3
    do_reset();
    BTNR = 1'b1;
    wait_n(12);
    check("r_select", difficulty, 3);
    pulses = 0;
    BTNR = 1'b0;
`ifdef DIFFICULTY_LATCH_EN
    wait_n(12);
    check("r_release_hold", difficulty, 3);
`else
    measure(0, lat);
    check("r_release_latency", lat, DEB + 3);
    wait_n(5);
`endif
    BTNR = 1'b1;
    wait_n(12);
    check("r_repress_difficulty", difficulty, 3);
`ifdef DIFFICULTY_LATCH_EN
    check("r_repress_pulses", pulses, 0);
`else
    check("r_repress_pulses", pulses, 2);
`endif
    BTNR = 1'b0;
    wait_n(12);

    // Reset mid-debounce with BTNC still held
    do_reset();
    BTNC = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    measure(2, lat);
    check("reset_mid_latency", lat, DEB + 3);
    BTNC = 1'b0;
    wait_n(12);

    // Random activity, occasional resets
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      if ($urandom_range(5) == 0) BTNL = ~BTNL;
      if ($urandom_range(5) == 0) BTNC = ~BTNC;
      if ($urandom_range(5) == 0) BTNR = ~BTNR;
      if ($urandom_range(7) == 0) BTND = ~BTND;
      reset = ($urandom_range(149) == 0);
    end
    reset = 1'b0;
    BTNL = 1'b0; BTNC = 1'b0; BTNR = 1'b0; BTND = 1'b0;
    wait_n(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
